ss_scanner: RTL and testbench



---
 rtl/ss_pkg.sv | 21 ++
 rtl/ss_scanner_if.sv | 40 ++++
 rtl/ss_slot_timer.sv | 54 +++++
 rtl/ss_scanner.sv | 144 ++++++++++++++
 tb/tb_ss_scanner.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared types for the seven-segment digit scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SS_CODE_W, slot state enum, per-digit store entry.
package ss_pkg;

  localparam int SS_CODE_W = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } ss_state_t;

  // code bit 0 is the MSB so it lines up with the driver's a[0:3].
  typedef struct packed {
    logic [0:SS_CODE_W-1] code;
    logic                 vis;
    logic                 blink;
  } ss_entry_t;

endpackage

// File: rtl/ss_scanner_if.sv
// Write port into the digit store plus the scanned outputs toward the segment driver.
// Latency: n/a (signal bundle only).
// Backpressure: none; writes are fire-and-forget strobes, outputs are free-running.
// Ports: master = game logic side (drives wr_*), slave = scanner (drives outputs).
// Build option: SS_SCANNER_BLINK_EN adds wr_blink.
interface ss_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int ADDR_W     = $clog2(NUM_DIGITS)
);
  import ss_pkg::*;

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [0:SS_CODE_W-1]  wr_code;
  logic                  wr_vis;
`ifdef SS_SCANNER_BLINK_EN
  logic                  wr_blink;
`endif
  logic [0:SS_CODE_W-1]  code_out;
  logic                  seg_enable;
  logic [NUM_DIGITS-1:0] digit_sel_n;
  logic                  frame_tick;

  modport master (
`ifdef SS_SCANNER_BLINK_EN
    output wr_blink,
`endif
    output wr_en, wr_addr, wr_code, wr_vis,
    input  code_out, seg_enable, digit_sel_n, frame_tick
  );

  modport slave (
`ifdef SS_SCANNER_BLINK_EN
    input  wr_blink,
`endif
    input  wr_en, wr_addr, wr_code, wr_vis,
    output code_out, seg_enable, digit_sel_n, frame_tick
  );

endinterface

// File: rtl/ss_slot_timer.sv
// Slot counter and BLANK/SHOW sequencing for one digit slot of PRESCALE cycles.
// Latency: o_slot_end / o_in_show are combinational from the current count.
// Backpressure: none; free-running from reset release.
// Ports: clk, rst_n; o_slot_end = last cycle of the slot;
//        o_in_show = state entered at the next edge is SHOW.
module ss_slot_timer
  import ss_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_slot_end,
  output logic o_in_show
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  ss_state_t        r_state;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_slot_end;
  ss_state_t        w_state_nxt;

  // One extra bit so cnt+1 never wraps before the compare.
  assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
  assign w_slot_end = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    if (w_slot_end)
      w_state_nxt = BLANK;
    else if (w_cnt_inc == BLANK_END)
      w_state_nxt = SHOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= BLANK;
    end else begin
      r_cnt   <= w_slot_end ? '0 : w_cnt_inc[CNT_W-1:0];
      r_state <= w_state_nxt;
    end
  end

  // The scanner registers its outputs from the upcoming state, so expose that.
  assign o_slot_end = w_slot_end;
  assign o_in_show  = (w_state_nxt == SHOW);

endmodule

// File: rtl/ss_scanner.sv
// Time-multiplexed digit scanner feeding the shared seven-segment driver.
// Latency: outputs registered; a store write at edge k is visible at edge k+1.
// Backpressure: none; writes always accepted (out-of-range addresses dropped).
// Ports: clk, rst_n (async, active-low), bus (ss_scanner_if.slave):
//        wr_en/wr_addr/wr_code/wr_vis[/wr_blink] in; code_out, seg_enable,
//        digit_sel_n (one-hot low), frame_tick out.
// Build option: SS_SCANNER_BLINK_EN adds per-digit blink and BLINK_FRAMES.
module ss_scanner
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ADDR_W       = $clog2(NUM_DIGITS)
`ifdef SS_SCANNER_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  ss_scanner_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  ss_entry_t             r_store [NUM_DIGITS];
  logic [IDX_W-1:0]      r_idx;
  logic [0:SS_CODE_W-1]  r_code;
  logic                  r_seg_en;
  logic [NUM_DIGITS-1:0] r_sel_n;
  logic                  r_tick;

  logic                  w_slot_end;
  logic                  w_in_show;
  logic                  w_frame_end;
  logic                  w_wr_ok;
  logic                  w_wr_blink;
  logic                  w_blank_gate;
  logic [IDX_W-1:0]      w_idx_nxt;
  ss_entry_t             w_entry;

  ss_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_slot_end (w_slot_end),
    .o_in_show  (w_in_show)
  );

  // ---------------- digit store ----------------
  assign w_wr_ok = bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS);

`ifdef SS_SCANNER_BLINK_EN
  assign w_wr_blink = bus.wr_blink;
`else
  assign w_wr_blink = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        r_store[i] <= '0;
    end else if (w_wr_ok) begin
      r_store[bus.wr_addr[IDX_W-1:0]] <= '{code: bus.wr_code, vis: bus.wr_vis, blink: w_wr_blink};
    end
  end

  // ---------------- digit index ----------------
  assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_slot_end)
      w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idx <= '0;
    else
      r_idx <= w_idx_nxt;
  end

  // Outputs follow the digit about to be active but the store as it stood
  // before this edge, giving the one-cycle write-to-display latency.
  assign w_entry = r_store[w_idx_nxt];

  // ---------------- blink phase ----------------
`ifdef SS_SCANNER_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] r_bf_cnt;
  logic            r_blink_on;
  logic            w_phase_wrap;
  logic            w_blink_on_nxt;

  assign w_phase_wrap   = w_frame_end && (r_bf_cnt == BF_LAST);
  assign w_blink_on_nxt = w_phase_wrap ? ~r_blink_on : r_blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bf_cnt   <= '0;
      r_blink_on <= 1'b1;
    end else if (w_frame_end) begin
      r_bf_cnt   <= w_phase_wrap ? '0 : r_bf_cnt + 1'b1;
      r_blink_on <= w_blink_on_nxt;
    end
  end

  // Use the phase being entered so the toggle lines up with the frame boundary.
  assign w_blank_gate = w_entry.blink && !w_blink_on_nxt;
`else
  logic w_unused_blink;
  // Stored blink bit has no consumer without blink support.
  assign w_unused_blink = w_entry.blink;
  assign w_blank_gate   = 1'b0;
`endif

  // ---------------- output registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code   <= '0;
      r_seg_en <= 1'b0;
      r_sel_n  <= '1;
      r_tick   <= 1'b0;
    end else begin
      r_code   <= w_entry.code;
      r_seg_en <= w_in_show && w_entry.vis && !w_blank_gate;
      r_sel_n  <= w_in_show ? ~(SEL_ONE << w_idx_nxt) : '1;
      r_tick   <= w_frame_end;
    end
  end

  assign bus.code_out    = r_code;
  assign bus.seg_enable  = r_seg_en;
  assign bus.digit_sel_n = r_sel_n;
  assign bus.frame_tick  = r_tick;

endmodule

// File: tb/tb_ss_scanner.sv
// Directed self-checking bench for ss_scanner (4 digits, 8-cycle slots, 2 blank cycles).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ss_scanner;
  import ss_pkg::*;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int AW = 3;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ss_scanner_if #(.NUM_DIGITS(ND), .ADDR_W(AW)) bus ();

  ss_scanner #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC),
    .ADDR_W       (AW)
`ifdef SS_SCANNER_BLINK_EN
    , .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [3:0] e_code  [ND];
  logic       e_vis   [ND];
  logic       e_blink [ND];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int addr, input logic [3:0] code, input logic vis, input logic blink);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_code = code;
    bus.wr_vis  = vis;
`ifdef SS_SCANNER_BLINK_EN
    bus.wr_blink = blink;
`else
    if (blink) $display("note: blink flag ignored in this build");
`endif
    step(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("frame_tick wait", 32'(bus.frame_tick), 32'd1);
  endtask

  // Walks whole frames from a frame-aligned position, checking every cycle.
  task automatic scan(input int nframes, input int start_c, input int frame0);
    int         nblank;
    logic       full;
    logic       off;
    logic [3:0] esel;
    logic       een;
    for (int f = 0; f < nframes; f++) begin
      for (int s = 0; s < ND; s++) begin
        nblank = 0;
        full   = !(f == 0 && s == 0 && start_c > 0);
        for (int c = 0; c < PS; c++) begin
          if (f == 0 && s == 0 && c < start_c) continue;
          off  = e_blink[s] && ((((frame0 + f) / BF) % 2) == 1);
          esel = (c < BC) ? 4'hF : ~(4'b0001 << s);
          een  = (c >= BC) && e_vis[s] && !off;
          if (bus.digit_sel_n == 4'hF) nblank++;
          chk($sformatf("code f%0d s%0d c%0d", f, s, c), 32'(bus.code_out), 32'(e_code[s]));
          chk($sformatf("sel f%0d s%0d c%0d", f, s, c), 32'(bus.digit_sel_n), 32'(esel));
          chk($sformatf("en f%0d s%0d c%0d", f, s, c), 32'(bus.seg_enable), 32'(een));
          chk($sformatf("tick f%0d s%0d c%0d", f, s, c), 32'(bus.frame_tick),
              32'(c == 0 && s == 0));
          step(1);
        end
        if (full) chk($sformatf("blank count f%0d s%0d", f, s), 32'(nblank), 32'(BC));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_code = '0;
    bus.wr_vis  = 1'b0;
`ifdef SS_SCANNER_BLINK_EN
    bus.wr_blink = 1'b0;
`endif
    for (int i = 0; i < ND; i++) begin
      e_code[i]  = 4'd0;
      e_vis[i]   = 1'b0;
      e_blink[i] = 1'b0;
    end

    // Reset values
    step(2);
    chk("rst code", 32'(bus.code_out), 32'd0);
    chk("rst en", 32'(bus.seg_enable), 32'd0);
    chk("rst sel", 32'(bus.digit_sel_n), 32'hF);
    chk("rst tick", 32'(bus.frame_tick), 32'd0);

    // First selection lands on edge BLANK_CYCLES after release
    rst_n = 1'b1;
    step(1);
    chk("edge1 sel", 32'(bus.digit_sel_n), 32'hF);
    step(1);
    chk("edge2 sel", 32'(bus.digit_sel_n), 32'hE);
    chk("edge2 en", 32'(bus.seg_enable), 32'd0);
    chk("edge2 code", 32'(bus.code_out), 32'd0);

    // Scan order, blanking and overlap over three frames
    for (int i = 0; i < ND; i++) begin
      wr(i, 4'(i + 1), 1'b1, 1'b0);
      e_code[i] = 4'(i + 1);
      e_vis[i]  = 1'b1;
    end
    wait_tick();
    scan(3, 0, 0);

    // Live write to the digit being shown (slot 1, cnt 4)
    step(12);
    chk("live pre sel", 32'(bus.digit_sel_n), 32'hD);
    chk("live pre code", 32'(bus.code_out), 32'h2);
    wr(1, 4'hA, 1'b1, 1'b0);
    chk("live write edge code", 32'(bus.code_out), 32'h2);
    step(1);
    chk("live next code", 32'(bus.code_out), 32'hA);
    chk("live next en", 32'(bus.seg_enable), 32'd1);
    step(1);
    chk("live last sel", 32'(bus.digit_sel_n), 32'hD);
    step(1);
    chk("live slot end sel", 32'(bus.digit_sel_n), 32'hF);
    chk("live slot end code", 32'(bus.code_out), 32'h3);
    e_code[1] = 4'hA;

    // Out-of-range address must not alias onto digit 1
    wr(5, 4'hF, 1'b0, 1'b0);
    wait_tick();
    scan(1, 0, 0);

    // Invisible digit still gets selected
    wr(2, 4'h3, 1'b0, 1'b0);
    e_vis[2] = 1'b0;
    wait_tick();
    scan(1, 0, 0);

    // Asynchronous reset in the middle of a SHOW cycle
    step(4);
    chk("pre-reset sel", 32'(bus.digit_sel_n), 32'hE);
    chk("pre-reset en", 32'(bus.seg_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst sel", 32'(bus.digit_sel_n), 32'hF);
    chk("async rst en", 32'(bus.seg_enable), 32'd0);
    chk("async rst code", 32'(bus.code_out), 32'd0);
    chk("async rst tick", 32'(bus.frame_tick), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("re-release edge1 sel", 32'(bus.digit_sel_n), 32'hF);
    step(1);
    chk("re-release edge2 sel", 32'(bus.digit_sel_n), 32'hE);
    chk("re-release edge2 code", 32'(bus.code_out), 32'd0);
    chk("re-release edge2 en", 32'(bus.seg_enable), 32'd0);

`ifdef SS_SCANNER_BLINK_EN
    // Blink on digit 0: on for frames 0-1, off 2-3, on 4-5
    rst_n = 1'b0;
    step(2);
    for (int i = 0; i < ND; i++) begin
      e_code[i]  = 4'd0;
      e_vis[i]   = 1'b0;
      e_blink[i] = 1'b0;
    end
    e_code[0]  = 4'h5;
    e_vis[0]   = 1'b1;
    e_blink[0] = 1'b1;
    rst_n = 1'b1;
    wr(0, 4'h5, 1'b1, 1'b1);
    bus.wr_blink = 1'b0;
    step(1);
    scan(6, 2, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
